// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and bus-field widths for the IF/D memory port arbiter.
// Optional watchdog is enabled by defining MEM_ARB_TIMEOUT_EN.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;

    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// BUSY-cycle counter for the arbiter; built only with MEM_ARB_TIMEOUT_EN.
// expired is high in the BUSY cycle where the count reaches TIMEOUT_CYCLES-1.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_in_n,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_in_n) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = run && (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and load/store.
// Define MEM_ARB_TIMEOUT_EN to add a BUSY watchdog and sticky mem_err.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          reset_in_n,
    input  logic                          if_req,
    input  logic [ADDR_W-1:0]             if_addr,
    output logic [DATA_W-1:0]             if_rdata,
    output logic                          if_valid,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [DATA_W-1:0]             d_wdata,
    input  logic [be_width(DATA_W)-1:0]   d_be,
    output logic [DATA_W-1:0]             d_rdata,
    output logic                          d_valid,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [be_width(DATA_W)-1:0]   mem_be,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          mem_wait,
    output logic                          mem_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    state_t state, state_next;
    logic   grant, grant_sel, last_grant;
    logic   grant_fire, done, timeout;
    logic [DATA_W-1:0] rd_val;

    always_ff @(posedge clk) begin
        if (!reset_in_n) state <= IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_fire = 1'b0;
        grant_sel  = REQ_IF;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    grant_fire = 1'b1;
                    state_next = BUSY;
                    if (if_req && d_req) grant_sel = ~last_grant;
                    else                 grant_sel = d_req ? REQ_D : REQ_IF;
                end
            end
            BUSY: begin
                if (mem_ack || timeout) begin
                    done       = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A watchdog expiry without ack returns zero data
    assign rd_val = mem_ack ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (!reset_in_n) begin
            grant      <= REQ_IF;
            last_grant <= REQ_D;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if (grant_fire) begin
                grant   <= grant_sel;
                mem_req <= 1'b1;
                if (grant_sel == REQ_D) begin
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    mem_be    <= d_be;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                    mem_be    <= '1;
                end
            end
            if (done) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (grant == REQ_D) begin
                    d_rdata <= rd_val;
                    d_valid <= 1'b1;
                end else begin
                    if_rdata <= rd_val;
                    if_valid <= 1'b1;
                end
            end
            if (state == RESP) last_grant <= grant;
        end
    end

    assign mem_wait = (d_req & ~d_valid) | (if_req & ~if_valid);

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset_in_n(reset_in_n),
        .run       (state == BUSY),
        .expired   (timeout)
    );

    always_ff @(posedge clk) begin
        if (!reset_in_n)                   mem_err <= 1'b0;
        else if (state == BUSY && timeout && !mem_ack) mem_err <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// The watchdog section runs only when built with MEM_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_in_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_wait;
    logic        mem_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk       (clk),
        .reset_in_n(reset_in_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_wait  (mem_wait),
        .mem_err   (mem_err)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_in_n = 1'b0;
        tick();
        reset_in_n = 1'b1;
    endtask

    initial begin
        reset_in_n = 1'b0;
        if_req = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        mem_ack = 0; mem_rdata = 0;
        tick(); tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_mem_wait", mem_wait, 0);
        check("rst_mem_err", mem_err, 0);
        reset_in_n = 1'b1;
        tick();

        // reset in the middle of BUSY
        if_req = 1; if_addr = 32'h200;
        tick();
        check("t1_busy_req", mem_req, 1);
        reset_in_n = 0; if_req = 0;
        tick();
        check("t1_rst_req", mem_req, 0);
        check("t1_rst_addr", mem_addr, 0);
        check("t1_rst_be", mem_be, 0);
        check("t1_rst_ifv", if_valid, 0);
        reset_in_n = 1;
        if_req = 1; if_addr = 32'h300;
        tick();
        check("t1_regrant_req", mem_req, 1);
        check("t1_regrant_addr", mem_addr, 32'h300);
        mem_ack = 1; mem_rdata = 32'h55;
        tick();
        check("t1_ifv", if_valid, 1);
        if_req = 0; mem_ack = 0;
        tick();

        // IF-only read
        if_req = 1; if_addr = 32'h100;
        tick();
        check("t2_req", mem_req, 1);
        check("t2_addr", mem_addr, 32'h100);
        check("t2_we", mem_we, 0);
        check("t2_be", mem_be, 4'hF);
        check("t2_wait", mem_wait, 1);
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        check("t2_ifv", if_valid, 1);
        check("t2_rdata", if_rdata, 32'hDEADBEEF);
        check("t2_req_drop", mem_req, 0);
        check("t2_wait_lo", mem_wait, 0);
        check("t2_dv", d_valid, 0);
        if_req = 0; mem_ack = 0;
        tick();
        check("t2_ifv_1cyc", if_valid, 0);

        // stray ack in IDLE
        mem_ack = 1;
        tick();
        check("t5_ifv", if_valid, 0);
        check("t5_dv", d_valid, 0);
        check("t5_req", mem_req, 0);
        mem_ack = 0;
        tick();
        check("t5_ifv2", if_valid, 0);
        check("t5_dv2", d_valid, 0);

        // simultaneous requests after reset
        do_reset();
        if_req = 1; if_addr = 32'h400;
        d_req = 1; d_we = 1; d_addr = 32'h800;
        d_wdata = 32'hCAFEF00D; d_be = 4'hC;
        tick();
        check("t3_first_addr", mem_addr, 32'h400);
        check("t3_first_we", mem_we, 0);
        mem_ack = 1; mem_rdata = 32'h11111111;
        tick();
        check("t3_ifv", if_valid, 1);
        check("t3_ifrd", if_rdata, 32'h11111111);
        check("t3_wait_d", mem_wait, 1);
        if_req = 0; mem_ack = 0;
        tick();
        check("t3_no_regrant", mem_req, 0);
        tick();
        check("t3_d_req", mem_req, 1);
        check("t3_d_addr", mem_addr, 32'h800);
        check("t3_d_we", mem_we, 1);
        check("t3_d_wdata", mem_wdata, 32'hCAFEF00D);
        check("t3_d_be", mem_be, 4'hC);
        mem_ack = 1; mem_rdata = 32'h22222222;
        tick();
        check("t3_dv", d_valid, 1);
        check("t3_drd", d_rdata, 32'h22222222);
        d_req = 0; mem_ack = 0;
        tick();
        if_req = 1; if_addr = 32'h404;
        d_req = 1; d_we = 0; d_addr = 32'h808; d_be = 4'hF;
        tick();
        check("t3_tie2_addr", mem_addr, 32'h404);
        mem_ack = 1; mem_rdata = 32'h33333333;
        tick();
        check("t3_tie2_ifv", if_valid, 1);
        if_req = 0; mem_ack = 0;
        tick(); tick();
        check("t3_d2_addr", mem_addr, 32'h808);
        check("t3_d2_we", mem_we, 0);
        mem_ack = 1; mem_rdata = 32'h44444444;
        tick();
        check("t3_d2_rd", d_rdata, 32'h44444444);
        d_req = 0; mem_ack = 0;
        tick();

        // store with slow ack
        d_req = 1; d_we = 1; d_addr = 32'h900;
        d_wdata = 32'h12345678; d_be = 4'b0011;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t4_req", mem_req, 1);
            check("t4_addr", mem_addr, 32'h900);
            check("t4_wdata", mem_wdata, 32'h12345678);
            check("t4_be", mem_be, 4'b0011);
            check("t4_we", mem_we, 1);
            check("t4_wait", mem_wait, 1);
            check("t4_dv_lo", d_valid, 0);
            tick();
        end
        mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
        check("t4_wait_ack", mem_wait, 1);
        tick();
        check("t4_dv", d_valid, 1);
        check("t4_drd", d_rdata, 32'hA5A5A5A5);
        check("t4_wait_lo", mem_wait, 0);
        d_req = 0; mem_ack = 0;
        tick();
        check("t4_dv_1cyc", d_valid, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        d_req = 1; d_we = 0; d_addr = 32'hA00;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("t6_req_held", mem_req, 1);
            check("t6_dv_lo", d_valid, 0);
            check("t6_err_lo", mem_err, 0);
            tick();
        end
        check("t6_req_drop", mem_req, 0);
        check("t6_dv", d_valid, 1);
        check("t6_drd", d_rdata, 0);
        check("t6_err", mem_err, 1);
        d_req = 0;
        tick();
        check("t6_dv_1cyc", d_valid, 0);
        check("t6_err_sticky", mem_err, 1);
        tick();
        check("t6_err_sticky2", mem_err, 1);
        do_reset();
        check("t6_err_rst", mem_err, 0);
`else
        check("no_to_err", mem_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
